// File: rtl/cook_timer_pkg.sv
// Shared definitions for the cook timer: state encodings, BCD limits and the MM:SS time record.
// Pure declarations; no logic, no latency, no flow control.
package cook_timer_pkg;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] MAX_DIGIT    = 4'd9;
   localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SET   = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef struct packed {
      logic [BCD_W-1:0] min_t;
      logic [BCD_W-1:0] min_o;
      logic [BCD_W-1:0] sec_t;
      logic [BCD_W-1:0] sec_o;
   } bcd_time_t;

endpackage

// File: rtl/cook_timer_tick_prescaler.sv
// Counts divider ticks into seconds; wrap is combinational and fires on the tick that closes a second.
// No backpressure: clr beats en, and ticks seen while en is low are dropped.
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic tick,
   output logic wrap
);

   localparam int CW = $clog2(TICKS_PER_SEC);
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   assign wrap = en && tick && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && tick) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cook_timer.sv
// Microwave MM:SS cook timer: keypad entry, countdown, pause/door interlock and end beep; outputs registered, one-cycle response.
// Request strobes are single-cycle and never stalled; priority is cancel > door_open > pause > start > key_valid.
module cook_timer
   import cook_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1000,
   parameter int BEEP_SECS     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             key_valid,
   input  logic [BCD_W-1:0] key_digit,
   input  logic             start,
   input  logic             pause,
   input  logic             cancel,
   input  logic             door_open,
   output logic [BCD_W-1:0] min_t,
   output logic [BCD_W-1:0] min_o,
   output logic [BCD_W-1:0] sec_t,
   output logic [BCD_W-1:0] sec_o,
   output logic             heat_o,
   output logic             beep_o,
   output logic [2:0]       state_o
);

   localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

   function automatic bcd_time_t bcd_dec(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.sec_o != '0) begin
         r.sec_o = t.sec_o - 1'b1;
      end else begin
         r.sec_o = MAX_DIGIT;
         if (t.sec_t != '0) begin
            r.sec_t = t.sec_t - 1'b1;
         end else begin
            r.sec_t = MAX_SEC_TENS;
            if (t.min_o != '0) begin
               r.min_o = t.min_o - 1'b1;
            end else begin
               r.min_o = MAX_DIGIT;
               r.min_t = t.min_t - 1'b1;
            end
         end
      end
      return r;
   endfunction

   function automatic bcd_time_t bcd_shift(input bcd_time_t t, input logic [BCD_W-1:0] d);
      bcd_time_t r;
      r.min_t = t.min_o;
      r.min_o = t.sec_t;
      r.sec_t = t.sec_o;
      r.sec_o = d;
      return r;
   endfunction

   logic [2:0]    state, state_nxt;
   bcd_time_t     tm, tm_nxt, tm_dec;
   logic [BW-1:0] beep_cnt, beep_cnt_nxt;
   logic          ps_clr, ps_en, wrap;
   logic          start_ok, key_ok;

   // Lower-priority requests only act when nothing above them is asserted.
   assign start_ok = start && !cancel && !door_open && !pause;
   assign key_ok   = key_valid && (key_digit <= MAX_DIGIT) && !cancel && !door_open && !pause && !start;
   assign ps_en    = ((state == ST_RUN) && !cancel && !door_open && !pause) ||
                     ((state == ST_DONE) && !cancel && !start_ok);
   assign tm_dec   = bcd_dec(tm);

   tick_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (ps_clr),
      .en   (ps_en),
      .tick (tick),
      .wrap (wrap)
   );

   always_comb begin
      state_nxt    = state;
      tm_nxt       = tm;
      beep_cnt_nxt = beep_cnt;
      ps_clr       = 1'b0;
      if (cancel) begin
         state_nxt    = ST_IDLE;
         tm_nxt       = '0;
         beep_cnt_nxt = '0;
         ps_clr       = 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_SET: begin
               if (start_ok && (state == ST_SET) && (tm != '0)) begin
                  state_nxt = ST_RUN;
                  ps_clr    = 1'b1;
               end else if (key_ok) begin
                  tm_nxt    = bcd_shift(tm, key_digit);
                  state_nxt = ST_SET;
               end
            end
            ST_RUN: begin
               if (door_open || pause) begin
                  state_nxt = ST_PAUSE;
               end else if (wrap) begin
                  tm_nxt = tm_dec;
                  if (tm_dec == '0) begin
                     state_nxt    = ST_DONE;
                     beep_cnt_nxt = '0;
                  end
               end
            end
            ST_PAUSE: begin
               if (start_ok) state_nxt = ST_RUN;
            end
            ST_DONE: begin
               if (start_ok) begin
                  state_nxt    = ST_IDLE;
                  beep_cnt_nxt = '0;
                  ps_clr       = 1'b1;
               end else if (wrap) begin
                  if (beep_cnt == BEEP_LAST) begin
                     state_nxt    = ST_IDLE;
                     beep_cnt_nxt = '0;
                  end else begin
                     beep_cnt_nxt = beep_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               tm_nxt    = '0;
               ps_clr    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tm       <= '0;
         beep_cnt <= '0;
         heat_o   <= 1'b0;
         beep_o   <= 1'b0;
      end else begin
         state    <= state_nxt;
         tm       <= tm_nxt;
         beep_cnt <= beep_cnt_nxt;
         heat_o   <= (state_nxt == ST_RUN);
         beep_o   <= (state_nxt == ST_DONE);
      end
   end

   assign min_t   = tm.min_t;
   assign min_o   = tm.min_o;
   assign sec_t   = tm.sec_t;
   assign sec_o   = tm.sec_o;
   assign state_o = state;

endmodule
